// File: rtl/ctrl_pkg.sv
// -----------------------------------------------------------------------------
// ctrl_pkg
// Shared definitions for the multicycle controller: FSM state encoding,
// RV32 opcode constants, funct3 values and ALU control encodings.
// -----------------------------------------------------------------------------
package ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    EXEC_R   = 4'd3,
    EXEC_I   = 4'd4,
    MEM_ADDR = 4'd5,
    MEM_RD   = 4'd6,
    MEM_WR   = 4'd7,
    WB       = 4'd8,
    BRANCH   = 4'd9,
    HALT     = 4'd10
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b100
  } alu_ctrl_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  // State that DECODE moves to for a given opcode, before funct checks.
  function automatic state_t dispatch(input logic [6:0] opcode);
    case (opcode)
      OP_R:               return EXEC_R;
      OP_I:               return EXEC_I;
      OP_LOAD, OP_STORE:  return MEM_ADDR;
      OP_BRANCH:          return BRANCH;
      default:            return HALT;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// -----------------------------------------------------------------------------
// alu_decoder
// Maps the state being entered plus funct3/funct7 to an ALU operation and
// flags encodings the controller does not support.
// Ports:
//   state    in   state the controller is dispatching to
//   funct3   in   instruction bits [14:12]
//   funct7   in   instruction bits [31:25]
//   alu_ctrl out  ALU operation for that state
//   illegal  out  1 when the funct fields are unsupported for that state
// -----------------------------------------------------------------------------
module alu_decoder
  import ctrl_pkg::*;
(
  input  state_t      state,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  output alu_ctrl_t   alu_ctrl,
  output logic        illegal
);

  // NOTE: every output gets a default before the case so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    alu_ctrl = ALU_ADD;
    illegal  = 1'b0;
    case (state)
      EXEC_R, EXEC_I: begin
        case (funct3)
          F3_ADD_SUB: begin
            // funct7 only selects add/sub for register-register ops.
            if (state == EXEC_I || funct7 == F7_BASE) alu_ctrl = ALU_ADD;
            else if (funct7 == F7_SUB)                alu_ctrl = ALU_SUB;
            else                                      illegal  = 1'b1;
          end
          F3_AND:  alu_ctrl = ALU_AND;
          F3_OR:   alu_ctrl = ALU_OR;
          F3_SLT:  alu_ctrl = ALU_SLT;
          default: illegal  = 1'b1;
        endcase
      end
      MEM_ADDR: alu_ctrl = ALU_ADD;
      BRANCH: begin
        alu_ctrl = ALU_SUB;
        illegal  = !(funct3 == F3_BEQ || funct3 == F3_BNE);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
// Multicycle RV32 subset controller: fetches an instruction word, latches it
// into ir, and sequences R-type, I-type, load, store and beq/bne through
// FETCH/DECODE/EXEC/MEM/WB/BRANCH. Unsupported encodings park the FSM in HALT
// until reset.
// Optional build macro MULTICYCLE_PERF_CNT_EN adds cycle_cnt and instret_cnt.
// Ports:
//   clk, rst     clock; asynchronous active-high reset
//   mem_rdata    instruction word, consumed in FETCH when mem_ready=1
//   mem_ready    handshake completion for the current mem_req
//   EQ           ALU equality flag, used in BRANCH
//   ir           latched instruction register
//   mem_req      memory request (FETCH, MEM_RD, MEM_WR)
//   mem_we       write qualifier (MEM_WR)
//   pc_we        PC update, once per retired instruction
//   PCsrc        0 = PC+4, 1 = branch target
//   we           register-file write enable (WB)
//   alu_src      1 = immediate operand
//   mem_to_reg   1 = writeback from memory
//   alu_ctrl     ALU operation (see ctrl_pkg::alu_ctrl_t)
//   halted       FSM is in HALT
//   cycle_cnt, instret_cnt  (MULTICYCLE_PERF_CNT_EN only) perf counters
// -----------------------------------------------------------------------------
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  // Must be at least 32: funct7 is taken from ir[31:25].
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  input  logic                  EQ,
  output logic [DATA_WIDTH-1:0] ir,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic                  pc_we,
  output logic                  PCsrc,
  output logic                  we,
  output logic                  alu_src,
  output logic                  mem_to_reg,
  output logic [2:0]            alu_ctrl,
  output logic                  halted
`ifdef MULTICYCLE_PERF_CNT_EN
  ,
  output logic [31:0]           cycle_cnt,
  output logic [31:0]           instret_cnt
`endif
);

  state_t    state;
  state_t    state_nxt;
  state_t    target;
  alu_ctrl_t dec_alu_ctrl;
  logic      dec_illegal;
  logic      pc_we_q;
  logic      is_load;
  logic      is_itype;

  assign target   = dispatch(ir[6:0]);
  assign is_load  = (ir[6:0] == OP_LOAD);
  assign is_itype = (ir[6:0] == OP_I);

  alu_decoder u_alu_decoder (
    .state    (target),
    .funct3   (ir[14:12]),
    .funct7   (ir[31:25]),
    .alu_ctrl (dec_alu_ctrl),
    .illegal  (dec_illegal)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:           state_nxt = FETCH;
      FETCH:          if (mem_ready) state_nxt = DECODE;
      DECODE:         state_nxt = dec_illegal ? HALT : target;
      EXEC_R, EXEC_I: state_nxt = WB;
      MEM_ADDR:       state_nxt = is_load ? MEM_RD : MEM_WR;
      MEM_RD:         if (mem_ready) state_nxt = WB;
      MEM_WR:         if (mem_ready) state_nxt = FETCH;
      WB, BRANCH:     state_nxt = FETCH;
      HALT:           state_nxt = HALT;
      default:        state_nxt = HALT;
    endcase
  end

  // State and Moore outputs share one register stage: each output is
  // computed from the state being entered, so it is a clean flop output
  // for the whole cycle that state is active.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ir         <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      we         <= 1'b0;
      alu_src    <= 1'b0;
      mem_to_reg <= 1'b0;
      alu_ctrl   <= ALU_ADD;
      halted     <= 1'b0;
      pc_we_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == FETCH && mem_ready) ir <= mem_rdata;
      mem_req    <= (state_nxt == FETCH) || (state_nxt == MEM_RD) ||
                    (state_nxt == MEM_WR);
      mem_we     <= (state_nxt == MEM_WR);
      we         <= (state_nxt == WB);
      // ir is already stable whenever WB is entered, so its opcode is valid.
      mem_to_reg <= (state_nxt == WB) && is_load;
      alu_src    <= (state_nxt == EXEC_I) || (state_nxt == MEM_ADDR) ||
                    ((state_nxt == WB) && (is_load || is_itype));
      // Only DECODE enters the ALU states, where the decoder reflects ir.
      alu_ctrl   <= ((state_nxt == EXEC_R) || (state_nxt == EXEC_I) ||
                     (state_nxt == MEM_ADDR) || (state_nxt == BRANCH))
                    ? dec_alu_ctrl : ALU_ADD;
      pc_we_q    <= (state_nxt == WB) || (state_nxt == BRANCH);
      halted     <= (state_nxt == HALT);
    end
  end

  // A store retires on the cycle its write handshake completes, which cannot
  // be known a cycle ahead; likewise the branch decision needs EQ from the
  // BRANCH cycle itself. Both are gated by the registered state.
  assign pc_we = pc_we_q || (state == MEM_WR && mem_ready);
  assign PCsrc = (state == BRANCH) &&
                 (((ir[14:12] == F3_BEQ) && EQ) ||
                  ((ir[14:12] == F3_BNE) && !EQ));

`ifdef MULTICYCLE_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (pc_we) instret_cnt <= instret_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, width of instruction and ir.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 mem_rdata  input  DATA_WIDTH  instruction word from memory, valid when mem_ready=1 in FETCH.
REQ-005 mem_ready  input  1  memory handshake completion for the current mem_req.
REQ-006 EQ  input  1  ALU equality flag, sampled in BRANCH.
REQ-007 ir  output  DATA_WIDTH  latched instruction register feeding register-file addresses and immediate generation.
REQ-008 mem_req, mem_we  output  1 each  memory request; write qualifier.
REQ-009 pc_we, PCsrc  output  1 each  PC update enable; 0=PC+4, 1=branch target.
REQ-010 we, alu_src, mem_to_reg  output  1 each  register write enable; 1=immediate operand; 1=writeback from memory.
REQ-011 alu_ctrl  output  3  000 add, 001 sub, 010 and, 011 or, 100 slt.
REQ-012 halted  output  1  set in HALT.

Function
REQ-013 States SHALL be IDLE, FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB, BRANCH, HALT.
REQ-014 Transitions: IDLE->FETCH unconditionally; FETCH waits until mem_ready=1, then ->DECODE.
REQ-015 DECODE dispatches on ir[6:0]: 0110011->EXEC_R; 0010011->EXEC_I; 0000011/0100011->MEM_ADDR; 1100011->BRANCH; any other->HALT.
REQ-016 EXEC_R, EXEC_I ->WB; MEM_ADDR->MEM_RD (load) or MEM_WR (store); MEM_RD waits until mem_ready=1, then ->WB; MEM_WR waits until mem_ready=1, then ->FETCH; WB, BRANCH ->FETCH; HALT holds until reset.
REQ-017 ir SHALL load mem_rdata only on the FETCH cycle with mem_ready=1, otherwise hold.
REQ-018 mem_req SHALL be 1 in FETCH, MEM_RD and MEM_WR, held continuously until mem_ready=1; mem_we=1 only in MEM_WR.
REQ-019 we SHALL pulse exactly one cycle in WB; mem_to_reg=1 in WB only when the instruction is a load.
REQ-020 alu_src=1 in EXEC_I, MEM_ADDR and WB of I-type, load and store; 0 otherwise.
REQ-021 alu_ctrl: EXEC_R from funct3/funct7 (000/0->add, 000/0100000->sub, 111->and, 110->or, 010->slt); EXEC_I same with funct7 ignored; MEM_ADDR add; BRANCH sub; unsupported funct3 SHALL go to HALT at DECODE.
REQ-022 pc_we SHALL pulse exactly once per instruction, in the final state (WB, MEM_WR on handshake, BRANCH), never in HALT.
REQ-023 PCsrc=1 only in BRANCH when taken: funct3 000 and EQ=1, or funct3 001 and EQ=0; other branch funct3 -> HALT.
REQ-024 Latency with mem_ready tied 1: R/I-type 4 cycles, load 5, store 4, branch 3; each wait cycle adds one.
REQ-025 mem_ready asserted outside FETCH/MEM_RD/MEM_WR SHALL be ignored.
REQ-026 All outputs SHALL be decoded from state and ir only, glitch-free relative to clk.

Reset
REQ-027 rst=1 SHALL force IDLE, ir=0 and all outputs 0 immediately, independent of clk, including mid-handshake.
REQ-028 First FETCH SHALL occur the second rising edge after rst deasserts.

Configuration
REQ-029 Macro MULTICYCLE_PERF_CNT_EN: when defined, add outputs cycle_cnt[31:0] (increments every non-reset cycle, wraps at 2^32) and instret_cnt[31:0] (increments on each pc_we); both reset to 0.
REQ-030 Without MULTICYCLE_PERF_CNT_EN the ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-031 Package ctrl_pkg SHALL hold the state enum, opcode constants and alu_ctrl encodings.
REQ-032 Sub-module alu_decoder SHALL map funct3/funct7/state to alu_ctrl and an illegal flag.

Verification
REQ-033 ir=0x00B50533 (add a0,a0,a1), mem_ready=1 -> FETCH,DECODE,EXEC_R,WB; we=1 and pc_we=1, PCsrc=0 in cycle 4 only.
REQ-034 mem_ready low 3 cycles in FETCH -> mem_req high 4 cycles, ir updates once, on the 4th.
REQ-035 bne (opcode 0x63, funct3 001) with EQ=0 -> BRANCH, pc_we=1, PCsrc=1; with EQ=1 -> PCsrc=0.
REQ-036 lw then sw, mem_ready=1 -> load 5 cycles, mem_to_reg=1 in WB; store mem_we=1 in MEM_WR, we never set.
REQ-037 Word 0x0000007F -> HALT, halted=1, mem_req stays 0 for 20 cycles; rst asserted in MEM_RD -> all outputs 0 at once.
